state_update_ctrl: RTL and testbench



---
 rtl/state_update_pkg.sv | 23 ++
 rtl/state_update_timer.sv | 23 ++
 rtl/state_update_ctrl.sv | 116 +++++++++++
 tb/tb_state_update_ctrl.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/state_update_pkg.sv
// Shared encodings for the state-update sequencer: output state codes,
// controller FSM states and the mod-4 step function.
package state_update_pkg;

  localparam logic [1:0] S0 = 2'b00;
  localparam logic [1:0] S1 = 2'b01;
  localparam logic [1:0] S2 = 2'b10;
  localparam logic [1:0] S3 = 2'b11;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    PULSE = 3'd2,
    HOLD  = 3'd3,
    DONE  = 3'd4
  } fsm_e;

  // S3 wraps to S0 through natural 2-bit overflow
  function automatic logic [1:0] step_next(input logic [1:0] s);
    return s + 2'd1;
  endfunction

endpackage

// File: rtl/state_update_timer.sv
// Loadable down-counter that parks at zero; o_zero flags the final cycle
// of the phase that loaded it.
module state_update_timer #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  output logic             o_zero
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                r_cnt <= '0;
    else if (i_load)        r_cnt <= i_load_val;
    else if (r_cnt != '0)   r_cnt <= r_cnt - 1'b1;
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/state_update_ctrl.sv
// Latch-stage sequencer: updates cur_state, then SETUP/PULSE/HOLD around
// latch_en, then a one-cycle ack. Optional self-stepping: STATE_UPDATE_CTRL_AUTORUN_EN.
module state_update_ctrl
  import state_update_pkg::*;
#(
  parameter int SETUP_CYC = 1,
  parameter int EN_PULSE  = 2,
  parameter int HOLD_CYC  = 1,
  parameter int CNT_W     = 4
`ifdef STATE_UPDATE_CTRL_AUTORUN_EN
  , parameter int AUTO_INTERVAL = 8
`endif
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       step_req,
  input  logic       load_req,
  input  logic [1:0] load_state,
`ifdef STATE_UPDATE_CTRL_AUTORUN_EN
  input  logic       auto_en,
`endif
  output logic [1:0] cur_state,
  output logic       latch_en,
  output logic       busy,
  output logic       ack
);

  localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(EN_PULSE - 1);
  localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'((HOLD_CYC > 0) ? HOLD_CYC - 1 : 0);

  fsm_e             r_fsm, w_fsm_nxt;
  logic             w_tmr_load, w_tmr_zero, w_accept, w_req, w_auto;
  logic [CNT_W-1:0] w_tmr_val;

  state_update_timer #(.CNT_W(CNT_W)) u_timer (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_tmr_load),
    .i_load_val (w_tmr_val),
    .o_zero     (w_tmr_zero)
  );

`ifdef STATE_UPDATE_CTRL_AUTORUN_EN
  localparam int IW = $clog2(AUTO_INTERVAL + 1);
  logic [IW-1:0] r_idle;

  // Self-step fires on the AUTO_INTERVAL-th consecutive request-free IDLE edge
  assign w_auto = auto_en && (r_fsm == IDLE) && !step_req && !load_req &&
                  (r_idle == IW'(AUTO_INTERVAL - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                                   r_idle <= '0;
    else if (!auto_en || r_fsm != IDLE || step_req || load_req || w_auto) r_idle <= '0;
    else                                                       r_idle <= r_idle + 1'b1;
  end
`else
  assign w_auto = 1'b0;
`endif

  assign w_req = step_req | load_req | w_auto;

  // DONE also accepts, so a held request restarts on the edge ending DONE
  always_comb begin
    w_fsm_nxt  = r_fsm;
    w_tmr_load = 1'b0;
    w_tmr_val  = '0;
    w_accept   = 1'b0;
    case (r_fsm)
      IDLE, DONE: begin
        if (w_req) begin
          w_fsm_nxt  = SETUP;
          w_tmr_load = 1'b1;
          w_tmr_val  = SETUP_LD;
          w_accept   = 1'b1;
        end else begin
          w_fsm_nxt  = IDLE;
        end
      end
      SETUP: if (w_tmr_zero) begin
        w_fsm_nxt  = PULSE;
        w_tmr_load = 1'b1;
        w_tmr_val  = PULSE_LD;
      end
      PULSE: if (w_tmr_zero) begin
        if (HOLD_CYC > 0) begin
          w_fsm_nxt  = HOLD;
          w_tmr_load = 1'b1;
          w_tmr_val  = HOLD_LD;
        end else begin
          w_fsm_nxt  = DONE;
        end
      end
      HOLD:    if (w_tmr_zero) w_fsm_nxt = DONE;
      default: w_fsm_nxt = IDLE;
    endcase
  end

  // Outputs are registered decodes of the next state, so they are glitch-free
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fsm     <= IDLE;
      cur_state <= S0;
      latch_en  <= 1'b0;
      busy      <= 1'b0;
      ack       <= 1'b0;
    end else begin
      r_fsm    <= w_fsm_nxt;
      latch_en <= (w_fsm_nxt == PULSE);
      busy     <= (w_fsm_nxt inside {SETUP, PULSE, HOLD});
      ack      <= (w_fsm_nxt == DONE);
      if (w_accept) cur_state <= load_req ? load_state : step_next(cur_state);
    end
  end

endmodule

// File: tb/tb_state_update_ctrl.sv
// Randomized/directed bench for state_update_ctrl against a timeline model
// (outputs derived from the distance to the last accepted request edge).
module tb_state_update_ctrl;

  localparam int AUTO_N = 8;

  logic clk = 1'b0;
  logic rst;
  logic sa, la, sb, lb, auto_en_a, auto_en_b;
  logic [1:0] lsa, lsb, csa, csb;
  logic lea, bza, aka, leb, bzb, akb;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  bit         m_act  [2];
  int         m_k    [2];
  int         m_cs   [2];
  int         m_idle [2];
  logic [4:0] m_exp  [2];
  int P_S [2] = '{1, 3};
  int P_E [2] = '{2, 1};
  int P_H [2] = '{1, 0};

  always #5 clk = ~clk;

  state_update_ctrl u_dut_a (
    .clk(clk), .rst(rst), .step_req(sa), .load_req(la), .load_state(lsa),
`ifdef STATE_UPDATE_CTRL_AUTORUN_EN
    .auto_en(auto_en_a),
`endif
    .cur_state(csa), .latch_en(lea), .busy(bza), .ack(aka)
  );

  state_update_ctrl #(.SETUP_CYC(3), .EN_PULSE(1), .HOLD_CYC(0)) u_dut_b (
    .clk(clk), .rst(rst), .step_req(sb), .load_req(lb), .load_state(lsb),
`ifdef STATE_UPDATE_CTRL_AUTORUN_EN
    .auto_en(auto_en_b),
`endif
    .cur_state(csb), .latch_en(leb), .busy(bzb), .ack(akb)
  );

  task automatic model_reset;
    for (int i = 0; i < 2; i++) begin
      m_act[i] = 1'b0; m_k[i] = 0; m_cs[i] = 0; m_idle[i] = 0; m_exp[i] = '0;
    end
  endtask

  // A sequence started at edge k: busy for L edges, latch_en in [S,S+E),
  // ack at L; acceptable again from L+1, truly idle from L+2.
  task automatic model_step(input int i, input logic st, input logic ld,
                            input logic [1:0] lv, input logic aen);
    int  L, d;
    bit  el, idl, au;
    L   = P_S[i] + P_E[i] + P_H[i];
    d   = cyc - m_k[i];
    el  = !m_act[i] || d >= L + 1;
    idl = !m_act[i] || d >= L + 2;
    au  = 1'b0;
    if (idl && aen && !st && !ld) begin
      m_idle[i]++;
      if (m_idle[i] == AUTO_N) begin au = 1'b1; m_idle[i] = 0; end
    end else m_idle[i] = 0;
    if (el && (st || ld || au)) begin
      m_cs[i]  = ld ? int'(lv) : (m_cs[i] + 1) % 4;
      m_k[i]   = cyc;
      m_act[i] = 1'b1;
    end
    d = cyc - m_k[i];
    m_exp[i] = {2'(m_cs[i]), m_act[i] && d >= P_S[i] && d < P_S[i] + P_E[i],
                m_act[i] && d < L, m_act[i] && d == L};
  endtask

  task automatic tick;
    @(posedge clk);
    cyc++;
    if (rst) model_reset();
    else begin
      model_step(0, sa, la, lsa, auto_en_a);
      model_step(1, sb, lb, lsb, auto_en_b);
    end
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1; sa = 0; la = 0; lsa = 0; sb = 0; lb = 0; lsb = 0;
    auto_en_a = 0; auto_en_b = 0;
    model_reset();
    #1;
    checks++;
    if ({csa, lea, bza, aka} !== 5'b0) begin
      errors++; $display("FAIL reset_a got=%b exp=%b", {csa, lea, bza, aka}, 5'b0);
    end
    tick(); tick();
    rst = 1'b0;
    tick();
    checks++;
    if ({csa, lea, bza, aka, csb, leb, bzb, akb} !== {m_exp[0], m_exp[1]}) begin
      errors++; $display("FAIL reset_idle got=%b exp=%b", {csa, lea, bza, aka, csb, leb, bzb, akb}, {m_exp[0], m_exp[1]});
    end
  endtask

  task automatic test_back_to_back;
    int got_seq[$];
    int ack_at[$];
    int exp_seq[4] = '{1, 2, 3, 0};
    logic [1:0] prev_cs;
    logic prev_le;
    sa = 1'b1;
    prev_cs = csa; prev_le = lea;
    for (int i = 0; i <= 20; i++) begin
      tick();
      if (i == 15) sa = 1'b0;
      checks++;
      if ({csa, lea, bza, aka} !== m_exp[0]) begin
        errors++; $display("FAIL b2b_cycle i=%0d got=%b exp=%b", i, {csa, lea, bza, aka}, m_exp[0]);
      end
      if (prev_le === 1'b1) begin
        checks++;
        if (csa !== prev_cs) begin
          errors++; $display("FAIL b2b_stable i=%0d got=%b exp=%b", i, csa, prev_cs);
        end
      end
      if (csa !== prev_cs) got_seq.push_back(int'(csa));
      if (aka === 1'b1) ack_at.push_back(i);
      prev_cs = csa; prev_le = lea;
    end
    checks++;
    if (got_seq.size() != 4) begin
      errors++; $display("FAIL b2b_seq_len got=%0d exp=4", got_seq.size());
    end else begin
      for (int j = 0; j < 4; j++) begin
        checks++;
        if (got_seq[j] != exp_seq[j]) begin
          errors++; $display("FAIL b2b_seq j=%0d got=%0d exp=%0d", j, got_seq[j], exp_seq[j]);
        end
      end
    end
    checks++;
    if (ack_at.size() != 4) begin
      errors++; $display("FAIL b2b_ack_count got=%0d exp=4", ack_at.size());
    end else begin
      for (int j = 0; j < 3; j++) begin
        checks++;
        if (ack_at[j+1] - ack_at[j] != 5) begin
          errors++; $display("FAIL b2b_ack_gap j=%0d got=%0d exp=5", j, ack_at[j+1] - ack_at[j]);
        end
      end
    end
  endtask

  task automatic test_single_step;
    int acks;
    la = 1'b1; lsa = 2'b01;
    tick();
    la = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    sa = 1'b1;
    acks = 0;
    for (int i = 0; i <= 6; i++) begin
      tick();
      sa = 1'b0;
      if (i == 0) begin
        checks++;
        if (csa !== 2'b10) begin
          errors++; $display("FAIL step_state got=%b exp=%b", csa, 2'b10);
        end
      end
      checks++;
      if ({lea, bza, aka} !== {i >= 1 && i < 3, i < 4, i == 4}) begin
        errors++; $display("FAIL step_timing i=%0d got=%b exp=%b", i, {lea, bza, aka}, {i >= 1 && i < 3, i < 4, i == 4});
      end
      checks++;
      if ({csa, lea, bza, aka} !== m_exp[0]) begin
        errors++; $display("FAIL step_model i=%0d got=%b exp=%b", i, {csa, lea, bza, aka}, m_exp[0]);
      end
      if (aka === 1'b1) acks++;
    end
    checks++;
    if (acks != 1) begin
      errors++; $display("FAIL step_acks got=%0d exp=1", acks);
    end
  endtask

  task automatic test_priority;
    int acks;
    la = 1'b1; lsa = 2'b00;
    tick();
    la = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    sa = 1'b1; la = 1'b1; lsa = 2'b11;
    acks = 0;
    for (int i = 0; i <= 6; i++) begin
      tick();
      sa = 1'b0; la = 1'b0;
      checks++;
      if (csa !== 2'b11) begin
        errors++; $display("FAIL prio_state i=%0d got=%b exp=%b", i, csa, 2'b11);
      end
      checks++;
      if ({csa, lea, bza, aka} !== m_exp[0]) begin
        errors++; $display("FAIL prio_model i=%0d got=%b exp=%b", i, {csa, lea, bza, aka}, m_exp[0]);
      end
      if (aka === 1'b1) acks++;
    end
    checks++;
    if (acks != 1) begin
      errors++; $display("FAIL prio_acks got=%0d exp=1", acks);
    end
  endtask

  task automatic test_ignored;
    int acks;
    acks = 0;
    sa = 1'b1;
    for (int i = 0; i <= 7; i++) begin
      tick();
      sa = (i == 1);
      checks++;
      if (csa !== 2'b00) begin
        errors++; $display("FAIL ignore_state i=%0d got=%b exp=%b", i, csa, 2'b00);
      end
      checks++;
      if ({csa, lea, bza, aka} !== m_exp[0]) begin
        errors++; $display("FAIL ignore_model i=%0d got=%b exp=%b", i, {csa, lea, bza, aka}, m_exp[0]);
      end
      if (aka === 1'b1) acks++;
    end
    checks++;
    if (acks != 1) begin
      errors++; $display("FAIL ignore_acks got=%0d exp=1", acks);
    end
  endtask

  task automatic test_short_cfg;
    sb = 1'b1;
    for (int i = 0; i <= 6; i++) begin
      tick();
      sb = 1'b0;
      checks++;
      if ({leb, akb} !== {i == 3, i == 4}) begin
        errors++; $display("FAIL short_timing i=%0d got=%b exp=%b", i, {leb, akb}, {i == 3, i == 4});
      end
      checks++;
      if ({csb, leb, bzb, akb} !== m_exp[1]) begin
        errors++; $display("FAIL short_model i=%0d got=%b exp=%b", i, {csb, leb, bzb, akb}, m_exp[1]);
      end
    end
  endtask

  task automatic test_random;
    for (int i = 0; i < 300; i++) begin
      sa  = ($urandom_range(0, 3) == 0);
      la  = ($urandom_range(0, 5) == 0);
      lsa = 2'($urandom_range(0, 3));
      sb  = ($urandom_range(0, 3) == 0);
      lb  = ($urandom_range(0, 5) == 0);
      lsb = 2'($urandom_range(0, 3));
      tick();
      checks++;
      if ({csa, lea, bza, aka, csb, leb, bzb, akb} !== {m_exp[0], m_exp[1]}) begin
        errors++; $display("FAIL random i=%0d got=%b exp=%b", i, {csa, lea, bza, aka, csb, leb, bzb, akb}, {m_exp[0], m_exp[1]});
      end
    end
    sa = 0; la = 0; sb = 0; lb = 0;
    for (int i = 0; i < 8; i++) tick();
  endtask

  task automatic test_reset_mid_pulse;
    sa = 1'b1;
    tick();
    sa = 1'b0;
    tick(); tick();
    checks++;
    if (lea !== 1'b1) begin
      errors++; $display("FAIL midrst_pre got=%b exp=%b", lea, 1'b1);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({csa, lea, bza, aka} !== 5'b0) begin
      errors++; $display("FAIL midrst_async got=%b exp=%b", {csa, lea, bza, aka}, 5'b0);
    end
    tick();
    rst = 1'b0;
    tick();
    checks++;
    if ({csa, lea, bza, aka} !== m_exp[0]) begin
      errors++; $display("FAIL midrst_after got=%b exp=%b", {csa, lea, bza, aka}, m_exp[0]);
    end
  endtask

`ifdef STATE_UPDATE_CTRL_AUTORUN_EN
  task automatic test_autorun;
    int first_busy;
    first_busy = -1;
    auto_en_a = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bza === 1'b1 && first_busy < 0) first_busy = i;
      checks++;
      if ({csa, lea, bza, aka} !== m_exp[0]) begin
        errors++; $display("FAIL auto_model i=%0d got=%b exp=%b", i, {csa, lea, bza, aka}, m_exp[0]);
      end
    end
    checks++;
    if (first_busy != AUTO_N - 1) begin
      errors++; $display("FAIL auto_start got=%0d exp=%0d", first_busy, AUTO_N - 1);
    end
    auto_en_a = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_back_to_back();
    test_single_step();
    test_priority();
    test_ignored();
    test_short_cfg();
    test_random();
    test_reset_mid_pulse();
`ifdef STATE_UPDATE_CTRL_AUTORUN_EN
    test_autorun();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
